// File: rtl/mips_wb_pkg.sv
// Shared types and helpers for the MIPS register-file write-back path.
// The wb_port_arbiter build option WB_RR_EN selects round-robin arbitration.
package mips_wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef struct packed {
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LD} grant_e;

    typedef enum logic {LAST_ALU, LAST_LD} last_e;

    // One-hot register decode; $0 never shows up as a pending destination.
    function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
        logic [31:0] v;
        v       = 32'd0;
        v[addr] = 1'b1;
        v[0]    = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous request queue holding {addr, data}, with a decoded
// destination vector of all occupied entries for the pending-write scoreboard.
module wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [4:0]        din_addr,
    input  logic [DATA_W-1:0] din_data,
    output logic [4:0]        dout_addr,
    output logic [DATA_W-1:0] dout_data,
    output logic              empty,
    output logic              full,
    output logic [31:0]       addr_vec
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]        addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout_addr = addr_mem[rd_ptr];
    assign dout_data = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= din_addr;
            data_mem[wr_ptr] <= din_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_comb begin
        addr_vec = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((DEPTH + i - 32'(rd_ptr)) % DEPTH) < 32'(count)) begin
                addr_vec = addr_vec | reg_onehot(addr_mem[i]);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port controller: queues ALU and load writes and arbitrates the single
// register-file write port. Define WB_RR_EN for round-robin, else loads have priority.
module wb_port_arbiter
    import mips_wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic              alu_reg_dst,
    input  logic [4:0]        alu_rt,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rt,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pending
);

    logic              alu_full, alu_empty, ld_full, ld_empty;
    logic [4:0]        alu_head_addr, ld_head_addr;
    logic [DATA_W-1:0] alu_head_data, ld_head_data;
    logic [31:0]       alu_vec, ld_vec;
    logic [4:0]        alu_dst;
    grant_e            gnt;

    assign alu_ready = !alu_full;
    assign ld_ready  = !ld_full;
    assign alu_dst   = alu_reg_dst ? alu_rd : alu_rt;

    wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_alu_q (
        .clk       (clk),
        .reset     (reset),
        .push      (alu_valid && alu_ready),
        .pop       (gnt == GNT_ALU),
        .din_addr  (alu_dst),
        .din_data  (alu_data),
        .dout_addr (alu_head_addr),
        .dout_data (alu_head_data),
        .empty     (alu_empty),
        .full      (alu_full),
        .addr_vec  (alu_vec)
    );

    wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ld_q (
        .clk       (clk),
        .reset     (reset),
        .push      (ld_valid && ld_ready),
        .pop       (gnt == GNT_LD),
        .din_addr  (ld_rt),
        .din_data  (ld_data),
        .dout_addr (ld_head_addr),
        .dout_data (ld_head_data),
        .empty     (ld_empty),
        .full      (ld_full),
        .addr_vec  (ld_vec)
    );

`ifdef WB_RR_EN
    last_e last_q;

    always_comb begin
        gnt = GNT_NONE;
        if (!alu_empty && !ld_empty) gnt = (last_q == LAST_ALU) ? GNT_LD : GNT_ALU;
        else if (!alu_empty)         gnt = GNT_ALU;
        else if (!ld_empty)          gnt = GNT_LD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= LAST_LD;
        end else if (gnt == GNT_ALU) begin
            last_q <= LAST_ALU;
        end else if (gnt == GNT_LD) begin
            last_q <= LAST_LD;
        end
    end
`else
    always_comb begin
        gnt = GNT_NONE;
        if (!ld_empty)       gnt = GNT_LD;
        else if (!alu_empty) gnt = GNT_ALU;
    end
`endif

    // Writes to $0 still pass through the output stage, only with the enable low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= REG_ZERO;
            rf_wdata <= '0;
        end else begin
            unique case (gnt)
                GNT_ALU: begin
                    rf_we    <= (alu_head_addr != REG_ZERO);
                    rf_waddr <= alu_head_addr;
                    rf_wdata <= alu_head_data;
                end
                GNT_LD: begin
                    rf_we    <= (ld_head_addr != REG_ZERO);
                    rf_waddr <= ld_head_addr;
                    rf_wdata <= ld_head_data;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

    assign pending = alu_vec | ld_vec | (rf_we ? reg_onehot(rf_waddr) : 32'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; expectations follow WB_RR_EN
// when the bundle is built with that macro.
module tb_wb_port_arbiter;

`ifdef WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic        alu_reg_dst = 1'b0;
    logic [4:0]  alu_rt = 5'd0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rt = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int n_cmp = 0;
    int n_fail = 0;

    logic [4:0]  w_addr[$];
    logic [31:0] w_data[$];
    int          alu_acc[$];
    bit          rdy_log[$];

    wb_port_arbiter #(.DATA_W(32), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg_dst (alu_reg_dst),
        .alu_rt      (alu_rt),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rt       (ld_rt),
        .ld_data     (ld_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Streams nl loads and na ALU writes with full handshaking; edge index e = 0 is the
    // first edge. Logs every write, ALU acceptance edges and alu_ready after each edge.
    task automatic stream(input int nl, input logic [4:0] lbase, input int lmod,
                          input int na, input logic [4:0] abase, input int ncyc);
        int li = 0;
        int ai = 0;
        w_addr.delete();
        w_data.delete();
        alu_acc.delete();
        rdy_log.delete();
        if (nl > 0) begin
            ld_valid = 1'b1;
            ld_rt    = lbase;
            ld_data  = 32'h10AD_0000;
        end
        if (na > 0) begin
            alu_valid   = 1'b1;
            alu_reg_dst = 1'b1;
            alu_rd      = abase;
            alu_rt      = 5'd1;
            alu_data    = 32'hA100_0000;
        end
        for (int e = 0; e < ncyc; e++) begin
            bit la, aa;
            la = ld_valid && ld_ready;
            aa = alu_valid && alu_ready;
            tick();
            if (la) begin
                li++;
                if (li == nl) ld_valid = 1'b0;
                else begin
                    ld_rt   = 5'(32'(lbase) + li % lmod);
                    ld_data = 32'h10AD_0000 + li;
                end
            end
            if (aa) begin
                alu_acc.push_back(e);
                ai++;
                if (ai == na) alu_valid = 1'b0;
                else begin
                    alu_rd   = 5'(32'(abase) + ai);
                    alu_data = 32'hA100_0000 + ai;
                end
            end
            rdy_log.push_back(alu_ready);
            if (rf_we) begin
                w_addr.push_back(rf_waddr);
                w_data.push_back(rf_wdata);
            end
        end
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        int p;
        logic [4:0] t4_exp [7];

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_pending", pending, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_ld_ready", ld_ready, 1);
        tick();
        tick();
        reset = 1'b0;

        // Single ALU request, reg_dst selects rd
        alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd9; alu_rt = 5'd3;
        alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        check("t1_queued_we", rf_we, 0);
        check("t1_queued_pending", pending, 32'h0000_0200);
        tick();
        check("t1_we", rf_we, 1);
        check("t1_waddr", rf_waddr, 9);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_out_pending", pending, 32'h0000_0200);
        tick();
        check("t1_retired_we", rf_we, 0);
        check("t1_retired_pending", pending, 0);
        check("t1_hold_waddr", rf_waddr, 9);

        // Load and ALU accepted on the same edge
        ld_valid = 1'b1; ld_rt = 5'd4; ld_data = 32'h0000_0044;
        alu_valid = 1'b1; alu_reg_dst = 1'b0; alu_rt = 5'd7; alu_rd = 5'd1;
        alu_data = 32'h0000_0077;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        check("t2_pending", pending, 32'h0000_0090);
        tick();
        check("t2_first_we", rf_we, 1);
        check("t2_first_addr", rf_waddr, 4);
        check("t2_first_data", rf_wdata, 32'h44);
        check("t2_first_pending", pending, 32'h0000_0090);
        tick();
        check("t2_second_we", rf_we, 1);
        check("t2_second_addr", rf_waddr, 7);
        check("t2_second_data", rf_wdata, 32'h77);
        tick();
        check("t2_idle_we", rf_we, 0);
        check("t2_idle_pending", pending, 0);

        // 20 streaming loads against a single ALU write to $3
        stream(20, 5'd16, 8, 1, 5'd3, 26);
        p = RR ? 1 : 20;
        check("t2b_write_count", w_addr.size(), 21);
        for (int k = 0; k < 21; k++) begin
            logic [4:0]  ea;
            logic [31:0] ed;
            int          li;
            li = (k < p) ? k : k - 1;
            ea = (k == p) ? 5'd3 : 5'(16 + li % 8);
            ed = (k == p) ? 32'hA100_0000 : 32'h10AD_0000 + li;
            check($sformatf("t2b_addr[%0d]", k), (k < w_addr.size()) ? 32'(w_addr[k]) : 32'hx, 32'(ea));
            check($sformatf("t2b_data[%0d]", k), (k < w_data.size()) ? w_data[k] : 32'hx, ed);
        end
        check("t2b_pending_end", pending, 0);

        // ALU write to $0: granted but never enabled or pending
        alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd0; alu_rt = 5'd5;
        alu_data = 32'h1;
        tick();
        alu_valid = 1'b0;
        check("t3_pending_q", pending, 0);
        check("t3_alu_ready", alu_ready, 1);
        tick();
        check("t3_we", rf_we, 0);
        check("t3_pending_out", pending, 0);
        check("t3_wdata_loaded", rf_wdata, 32'h1);
        check("t3_waddr_loaded", rf_waddr, 0);
        tick();
        check("t3_we_after", rf_we, 0);

        // Fill the ALU queue while loads stream
        stream(4, 5'd20, 8, 3, 5'd24, 12);
        if (RR) t4_exp = '{5'd20, 5'd24, 5'd21, 5'd25, 5'd22, 5'd26, 5'd23};
        else    t4_exp = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
        check("t4_ready_e0", rdy_log[0], 1);
        check("t4_ready_full", rdy_log[1], 0);
        check("t4_ready_e2", rdy_log[2], RR ? 1 : 0);
        check("t4_alu_acc_n", alu_acc.size(), 3);
        check("t4_a1_edge", (alu_acc.size() > 1) ? alu_acc[1] : -1, 1);
        check("t4_a2_edge", (alu_acc.size() > 2) ? alu_acc[2] : -1, RR ? 3 : 6);
        check("t4_write_count", w_addr.size(), 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t4_addr[%0d]", k), (k < w_addr.size()) ? 32'(w_addr[k]) : 32'hx,
                  32'(t4_exp[k]));
        end

        // Asynchronous reset with a full queue and a write on the output stage
        alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
        ld_valid = 1'b1; ld_rt = 5'd14; ld_data = 32'h14;
        tick();
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("t5_pre_we", rf_we, 1);
        check("t5_pre_full", !alu_ready || !ld_ready, 1);
        check("t5_pre_pending", pending, 32'h0000_6000);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_we", rf_we, 0);
        check("t5_rst_waddr", rf_waddr, 0);
        check("t5_rst_wdata", rf_wdata, 0);
        check("t5_rst_pending", pending, 0);
        check("t5_rst_alu_ready", alu_ready, 1);
        check("t5_rst_ld_ready", ld_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("t5_post_we", rf_we, 0);
        check("t5_post_pending", pending, 0);

        // Two ALU writes to $12 retire in order
        alu_valid = 1'b1; alu_reg_dst = 1'b0; alu_rt = 5'd12; alu_rd = 5'd2;
        alu_data = 32'hAAAA_0001;
        tick();
        alu_data = 32'hBBBB_0002;
        check("t6_pending_a", pending, 32'h0000_1000);
        tick();
        alu_valid = 1'b0;
        check("t6_a_we", rf_we, 1);
        check("t6_a_addr", rf_waddr, 12);
        check("t6_a_data", rf_wdata, 32'hAAAA_0001);
        check("t6_a_pending", pending, 32'h0000_1000);
        tick();
        check("t6_b_we", rf_we, 1);
        check("t6_b_data", rf_wdata, 32'hBBBB_0002);
        check("t6_b_pending", pending, 32'h0000_1000);
        tick();
        check("t6_done_we", rf_we, 0);
        check("t6_done_pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
